rgmii_tx_ddr_prep: RTL and testbench

//  Sits directly upstream of the generic DDR output registers on the RGMII TX path. Converts GMII-style byte

---
 rtl/rgmii_tx_ddr_prep_if.sv | 23 ++
 rtl/rgmii_tx_ddr_prep.sv | 202 ++++++++++++++++++++
 tb/tb_rgmii_tx_ddr_prep.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_ddr_prep_if.sv
// rgmii_tx_ddr_prep_if
//  GMII-style byte transmit bundle between the upstream MAC and the RGMII
//  TX preparation block.
//  Signals:
//   gmii_txd     8  transmit byte
//   gmii_tx_en   1  frame valid
//   gmii_tx_er   1  transmit error
//   gmii_clk_en  1  byte strobe from the RGMII side; the next byte must be
//                   presented while it is high
//  Modports:
//   master  upstream MAC (drives data, receives strobe)
//   slave   rgmii_tx_ddr_prep (receives data, drives strobe)
interface rgmii_tx_ddr_prep_if;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_clk_en;

  modport master (output gmii_txd, output gmii_tx_en, output gmii_tx_er,
                  input gmii_clk_en);
  modport slave  (input gmii_txd, input gmii_tx_en, input gmii_tx_er,
                  output gmii_clk_en);
endinterface

// File: rtl/rgmii_tx_ddr_prep.sv
// rgmii_tx_ddr_prep
//  Prepares per-edge (rising/falling half) values for the RGMII TX DDR output
//  registers from GMII-style bytes. At 1000M a whole byte goes out per clk
//  (low nibble on the rising half, high nibble on the falling half). At
//  10/100M clk is divided down to the RGMII clock rate, one nibble is sent per
//  RGMII clock (low nibble first) and upstream is paced with gmii_clk_en.
//  Ports:
//   clk, rst_n        125 MHz clock, asynchronous active-low reset
//   speed[1:0]        10=1000M, 01=100M, 00=10M, 11 treated as 1000M
//   gmii              slave side of the GMII byte interface
//   txd_d1/txd_d2     TXD nibble for rising/falling half of clk
//   ctl_d1/ctl_d2     TX_CTL for rising (tx_en) / falling (tx_en^tx_er) half
//   clk_d1/clk_d2     TX_CLK level for rising/falling half of clk
module rgmii_tx_ddr_prep #(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                speed,
  rgmii_tx_ddr_prep_if.slave        gmii,
  output logic [3:0]                txd_d1,
  output logic [3:0]                txd_d2,
  output logic                      ctl_d1,
  output logic                      ctl_d2,
  output logic                      clk_d1,
  output logic                      clk_d2
);

  localparam int DMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CW   = $clog2(DMAX);

  localparam logic [CW-1:0] LAST_100 = CW'(DIV_100 - 1);
  localparam logic [CW-1:0] LAST_10  = CW'(DIV_10 - 1);
  localparam logic [CW-1:0] HALF_100 = CW'(DIV_100 / 2);
  localparam logic [CW-1:0] HALF_10  = CW'(DIV_10 / 2);
  localparam logic          ODD_100  = (DIV_100 % 2) == 1;
  localparam logic          ODD_10   = (DIV_10 % 2) == 1;

  logic [1:0]    speed_q;
  logic [CW-1:0] cnt;
  logic          ph;
  logic [3:0]    hi_nib;
  logic          en_q;
  logic          er_q;
  logic          clk_en_q;

  logic [1:0]    speed_norm;
  logic [1:0]    mode;
  logic          change;
  logic          gig;
  logic          sample;
  logic          wrap;
  logic [CW-1:0] last;
  logic [CW-1:0] half;
  logic          odd;

  logic [CW-1:0] cnt_nxt;
  logic          ph_nxt;
  logic [3:0]    hi_nib_nxt;
  logic          en_nxt;
  logic          er_nxt;
  logic          clk_en_nxt;
  logic [3:0]    txd_d1_nxt;
  logic [3:0]    txd_d2_nxt;
  logic          ctl_d1_nxt;
  logic          ctl_d2_nxt;
  logic          clk_d1_nxt;
  logic          clk_d2_nxt;

  assign gmii.gmii_clk_en = clk_en_q;

  // Mode decode. 2'b11 is folded onto 1000M so that toggling between the two
  // gigabit encodings never looks like a speed change. During a change edge
  // the new mode already governs the counter limits and clock pattern.
  always_comb begin
    speed_norm = (speed == 2'b11) ? 2'b10 : speed;
    change     = (speed_norm != speed_q);
    mode       = change ? speed_norm : speed_q;
    gig        = mode[1];
    last       = (mode == 2'b01) ? LAST_100 : LAST_10;
    half       = (mode == 2'b01) ? HALF_100 : HALF_10;
    odd        = (mode == 2'b01) ? ODD_100  : ODD_10;
    sample     = clk_en_q && !change;
    wrap       = (cnt == last);
  end

  // Next-state for the divider, nibble store and all registered outputs.
  // A speed change restarts the divider and drops whatever byte was in flight
  // (stored high nibble included), so nothing stale leaks out in the new mode.
  // In 10/100 a byte sample always coincides with the ph1->ph0 wrap, and the
  // ph0->ph1 wrap emits the stored high nibble.
  always_comb begin
    cnt_nxt    = cnt;
    ph_nxt     = ph;
    hi_nib_nxt = hi_nib;
    en_nxt     = en_q;
    er_nxt     = er_q;
    txd_d1_nxt = txd_d1;
    txd_d2_nxt = txd_d2;
    ctl_d1_nxt = ctl_d1;
    ctl_d2_nxt = ctl_d2;

    if (change) begin
      cnt_nxt    = '0;
      ph_nxt     = 1'b0;
      hi_nib_nxt = 4'h0;
      en_nxt     = 1'b0;
      er_nxt     = 1'b0;
      txd_d1_nxt = 4'h0;
      txd_d2_nxt = 4'h0;
      ctl_d1_nxt = 1'b0;
      ctl_d2_nxt = 1'b0;
    end else if (gig) begin
      cnt_nxt = '0;
      ph_nxt  = 1'b0;
      if (sample) begin
        txd_d1_nxt = gmii.gmii_txd[3:0];
        txd_d2_nxt = gmii.gmii_txd[7:4];
        ctl_d1_nxt = gmii.gmii_tx_en;
        ctl_d2_nxt = gmii.gmii_tx_en ^ gmii.gmii_tx_er;
      end
    end else begin
      if (wrap) begin
        cnt_nxt = '0;
        ph_nxt  = ~ph;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      if (sample) begin
        txd_d1_nxt = gmii.gmii_txd[3:0];
        txd_d2_nxt = gmii.gmii_txd[3:0];
        ctl_d1_nxt = gmii.gmii_tx_en;
        ctl_d2_nxt = gmii.gmii_tx_en ^ gmii.gmii_tx_er;
        hi_nib_nxt = gmii.gmii_txd[7:4];
        en_nxt     = gmii.gmii_tx_en;
        er_nxt     = gmii.gmii_tx_er;
      end else if (wrap && !ph) begin
        txd_d1_nxt = hi_nib;
        txd_d2_nxt = hi_nib;
        ctl_d1_nxt = en_q;
        ctl_d2_nxt = en_q ^ er_q;
      end
    end
  end

  // Strobe and TX_CLK pattern are computed from the next counter value so the
  // registered outputs line up with the data they accompany.
  always_comb begin
    clk_en_nxt = 1'b0;
    clk_d1_nxt = 1'b0;
    clk_d2_nxt = 1'b0;
    if (gig) begin
      clk_en_nxt = 1'b1;
      clk_d1_nxt = 1'b1;
      clk_d2_nxt = 1'b0;
    end else begin
      clk_en_nxt = ph_nxt && (cnt_nxt == last);
      if (cnt_nxt < half) begin
        clk_d1_nxt = 1'b1;
        clk_d2_nxt = 1'b1;
      end else if (odd && (cnt_nxt == half)) begin
        clk_d1_nxt = 1'b1;
        clk_d2_nxt = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q  <= 2'b10;
      cnt      <= '0;
      ph       <= 1'b0;
      hi_nib   <= 4'h0;
      en_q     <= 1'b0;
      er_q     <= 1'b0;
      clk_en_q <= 1'b0;
      txd_d1   <= 4'h0;
      txd_d2   <= 4'h0;
      ctl_d1   <= 1'b0;
      ctl_d2   <= 1'b0;
      clk_d1   <= 1'b0;
      clk_d2   <= 1'b0;
    end else begin
      speed_q  <= speed_norm;
      cnt      <= cnt_nxt;
      ph       <= ph_nxt;
      hi_nib   <= hi_nib_nxt;
      en_q     <= en_nxt;
      er_q     <= er_nxt;
      clk_en_q <= clk_en_nxt;
      txd_d1   <= txd_d1_nxt;
      txd_d2   <= txd_d2_nxt;
      ctl_d1   <= ctl_d1_nxt;
      ctl_d2   <= ctl_d2_nxt;
      clk_d1   <= clk_d1_nxt;
      clk_d2   <= clk_d2_nxt;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_ddr_prep.sv
// tb_rgmii_tx_ddr_prep
//  Directed testbench for rgmii_tx_ddr_prep with DIV_100=5, DIV_10=50.
//  Observed outputs are packed as {clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2,
//  clk_d1, clk_d2} and compared with hand-derived expected vectors.
module tb_rgmii_tx_ddr_prep;

  logic       clk;
  logic       rst_n;
  logic [1:0] speed;
  logic [3:0] txd_d1;
  logic [3:0] txd_d2;
  logic       ctl_d1;
  logic       ctl_d2;
  logic       clk_d1;
  logic       clk_d2;

  int n_cmp;
  int n_err;

  rgmii_tx_ddr_prep_if gmii ();

  rgmii_tx_ddr_prep #(.DIV_100(5), .DIV_10(50)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .speed  (speed),
    .gmii   (gmii.slave),
    .txd_d1 (txd_d1),
    .txd_d2 (txd_d2),
    .ctl_d1 (ctl_d1),
    .ctl_d2 (ctl_d2),
    .clk_d1 (clk_d1),
    .clk_d2 (clk_d2)
  );

  // 125 MHz style clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {gmii.gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2};
  endfunction

  // Expected TX_CLK pair for divider position c with divide ratio d.
  function automatic logic [1:0] clk_pat(int c, int d);
    if (c < d / 2) return 2'b11;
    if ((d % 2 == 1) && (c == d / 2)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic en, input logic er);
    gmii.gmii_txd   = d;
    gmii.gmii_tx_en = en;
    gmii.gmii_tx_er = er;
  endtask

  // Reset values, then the first cycle after release at 1000M.
  task automatic test_reset();
    logic [12:0] exp;
    rst_n = 1'b0;
    speed = 2'b10;
    drive(8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    exp = 13'h0;
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL reset: got %h expected %h", obs(), exp);
    end
    rst_n = 1'b1;
    tick();
    exp = {1'b1, 4'h0, 4'h0, 2'b00, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL gig_first: got %h expected %h", obs(), exp);
    end
  endtask

  // 1000M data and TX_CTL encoding including error cases.
  task automatic test_gig();
    logic [12:0] exp;
    drive(8'hA5, 1'b1, 1'b0);
    tick();
    exp = {1'b1, 4'h5, 4'hA, 2'b11, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL gig_a5: got %h expected %h", obs(), exp);
    end
    drive(8'h3C, 1'b1, 1'b1);
    tick();
    exp = {1'b1, 4'hC, 4'h3, 2'b10, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL gig_err: got %h expected %h", obs(), exp);
    end
    drive(8'h00, 1'b0, 1'b1);
    tick();
    exp = {1'b1, 4'h0, 4'h0, 2'b01, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL gig_carrier_ext: got %h expected %h", obs(), exp);
    end
  endtask

  // 1000M -> 100M mid-stream: zeroed nibble, strobe on the 10th cycle.
  task automatic test_switch_100();
    logic [12:0] got;
    speed = 2'b01;
    drive(8'h77, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tick();
      got = obs();
      n_cmp++;
      if ({got[12], got[1:0]} !== {(j == 9), clk_pat(j % 5, 5)}) begin
        n_err++;
        $display("[TB] FAIL sw100_clk j=%0d: got %h expected en=%0d clk=%b",
                 j, got, (j == 9), clk_pat(j % 5, 5));
      end
      if (j < 5) begin
        n_cmp++;
        if (got[11:2] !== 10'h0) begin
          n_err++;
          $display("[TB] FAIL sw100_zero j=%0d: got %h expected data 0", j, got);
        end
      end
    end
    drive(8'h3C, 1'b1, 1'b0);
  endtask

  // 100M stream 3C, 81 (with error), 5A; reset asserted at cnt=3 of 5A.
  task automatic test_stream_100();
    logic [3:0]  nib [5];
    logic [1:0]  ctl;
    logic [12:0] exp;
    nib[0] = 4'hC; nib[1] = 4'h3; nib[2] = 4'h1; nib[3] = 4'h8; nib[4] = 4'hA;
    for (int m = 0; m < 24; m++) begin
      tick();
      ctl = (m >= 10 && m < 20) ? 2'b10 : 2'b11;
      exp = {(m % 10 == 9), nib[m / 5], nib[m / 5], ctl, clk_pat(m % 5, 5)};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("[TB] FAIL stream100 m=%0d: got %h expected %h", m, obs(), exp);
      end
      if (m == 9)  drive(8'h81, 1'b1, 1'b1);
      if (m == 19) drive(8'h5A, 1'b1, 1'b0);
    end
  endtask

  // Asynchronous reset mid-byte, then restart at 100M.
  task automatic test_reset_mid();
    logic [12:0] got;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (obs() !== 13'h0) begin
      n_err++;
      $display("[TB] FAIL reset_mid: got %h expected %h", obs(), 13'h0);
    end
    drive(8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      got = obs();
      n_cmp++;
      if ({got[12], got[1:0]} !== {(j == 9), clk_pat(j % 5, 5)}) begin
        n_err++;
        $display("[TB] FAIL restart_clk j=%0d: got %h expected en=%0d clk=%b",
                 j, got, (j == 9), clk_pat(j % 5, 5));
      end
      if (j < 5) begin
        n_cmp++;
        if (got[11:2] !== 10'h0) begin
          n_err++;
          $display("[TB] FAIL restart_zero j=%0d: got %h expected data 0", j, got);
        end
      end
    end
  endtask

  // 100M -> 10M, then one byte F0 at 10M.
  task automatic test_10m();
    logic [12:0] got;
    logic [12:0] exp;
    logic [3:0]  n;
    speed = 2'b00;
    for (int j = 0; j < 100; j++) begin
      tick();
      got = obs();
      n_cmp++;
      if ({got[12], got[1:0]} !== {(j == 99), clk_pat(j % 50, 50)}) begin
        n_err++;
        $display("[TB] FAIL sw10_clk j=%0d: got %h expected en=%0d clk=%b",
                 j, got, (j == 99), clk_pat(j % 50, 50));
      end
      if (j < 50) begin
        n_cmp++;
        if (got[11:2] !== 10'h0) begin
          n_err++;
          $display("[TB] FAIL sw10_zero j=%0d: got %h expected data 0", j, got);
        end
      end
    end
    drive(8'hF0, 1'b1, 1'b0);
    for (int m = 0; m < 100; m++) begin
      tick();
      n = (m < 50) ? 4'h0 : 4'hF;
      exp = {(m == 99), n, n, 2'b11, clk_pat(m % 50, 50)};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("[TB] FAIL byte10 m=%0d: got %h expected %h", m, obs(), exp);
      end
    end
  endtask

  // Back to 1000M: one zeroed cycle with strobe up, then data; 2'b11 is gig.
  task automatic test_back_to_gig();
    logic [12:0] exp;
    speed = 2'b10;
    drive(8'hA5, 1'b1, 1'b0);
    tick();
    exp = {1'b1, 4'h0, 4'h0, 2'b00, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL swgig_zero: got %h expected %h", obs(), exp);
    end
    tick();
    exp = {1'b1, 4'h5, 4'hA, 2'b11, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL swgig_data: got %h expected %h", obs(), exp);
    end
    speed = 2'b11;
    drive(8'h96, 1'b1, 1'b0);
    tick();
    exp = {1'b1, 4'h6, 4'h9, 2'b11, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++;
      $display("[TB] FAIL speed11: got %h expected %h", obs(), exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_gig();
    test_switch_100();
    test_stream_100();
    test_reset_mid();
    test_10m();
    test_back_to_gig();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
